// File: rtl/iommu_l2_responder_if.sv
// iommu_l2_responder_if: IOMMU L2 request port plus word-RAM port of the L2 responder.
// The slave modport is the responder's view; master is the requester/RAM side.
interface iommu_l2_responder_if;
   logic [31:0]  l2_addr;
   logic         l2_request;
   logic         l2_write_en;
   logic [255:0] l2_write_data;
   logic [255:0] l2_data;
   logic         l2_done;
   logic [29:0]  ram_addr;
   logic         ram_read_en;
   logic         ram_write_en;
   logic [31:0]  ram_write_data;
   logic [31:0]  ram_read_data;
   modport slave (
      input  l2_addr, l2_request, l2_write_en, l2_write_data, ram_read_data,
      output l2_data, l2_done, ram_addr, ram_read_en, ram_write_en, ram_write_data
   );
   modport master (
      output l2_addr, l2_request, l2_write_en, l2_write_data, ram_read_data,
      input  l2_data, l2_done, ram_addr, ram_read_en, ram_write_en, ram_write_data
   );
endinterface

// File: rtl/iommu_l2_responder.sv
// iommu_l2_responder: direct-mapped 32-byte block buffer answering IOMMU L2 requests; misses fill from word RAM,
// writes allocate and write through. Define L2R_STATS_EN to add saturating hit_count/miss_count ports.
module iommu_l2_responder #(
   parameter int LINES = 16
) (
   input  logic                clk,
   input  logic                reset,
   iommu_l2_responder_if.slave bus
`ifdef L2R_STATS_EN
   ,
   output logic [15:0]         hit_count,
   output logic [15:0]         miss_count
`endif
);
   localparam int IDX = $clog2(LINES);
   localparam int TW  = 27 - IDX;
   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESPOND, WAIT_DROP} state_t;
   state_t         r_state;
   logic [26:0]    r_blk;
   logic           r_we;
   logic [255:0]   r_wdata;
   logic [255:0]   r_lines [LINES];
   logic [TW-1:0]  r_tags [LINES];
   logic [LINES-1:0] r_valid;
   logic [255:0]   r_fill;
   logic           r_pend;
   logic [2:0]     r_pbeat;
   logic [255:0]   r_l2_data;
   logic           r_done;
   logic           r_ren;
   logic           r_wen;
   logic [29:0]    r_raddr;
   logic [31:0]    r_ram_wdata;
   logic [IDX-1:0] w_idx;
   logic [TW-1:0]  w_tag;
   logic           w_hit;
   logic [2:0]     w_beat;
   logic [255:0]   w_fill_next;
   logic           w_unused;
   assign w_idx    = r_blk[IDX-1:0];
   assign w_tag    = r_blk[26:IDX];
   assign w_hit    = r_valid[w_idx] && r_tags[w_idx] == w_tag;
   assign w_beat   = r_raddr[2:0];
   assign w_unused = ^bus.l2_addr[4:0];
   // The word arriving this cycle belongs to the beat issued one cycle earlier.
   always_comb begin
      w_fill_next = r_fill;
      w_fill_next[32*r_pbeat +: 32] = bus.ram_read_data;
   end
`ifdef L2R_STATS_EN
   logic [15:0] r_hit_count;
   logic [15:0] r_miss_count;
   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_valid     <= '0;
         r_blk       <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_fill      <= '0;
         r_pend      <= 1'b0;
         r_pbeat     <= '0;
         r_l2_data   <= '0;
         r_done      <= 1'b0;
         r_ren       <= 1'b0;
         r_wen       <= 1'b0;
         r_raddr     <= '0;
         r_ram_wdata <= '0;
`ifdef L2R_STATS_EN
         r_hit_count  <= '0;
         r_miss_count <= '0;
`endif
      end else begin
         unique case (r_state)
            IDLE: if (bus.l2_request) begin
               r_blk   <= bus.l2_addr[31:5];
               r_we    <= bus.l2_write_en;
               r_wdata <= bus.l2_write_data;
               r_state <= LOOKUP;
            end
            LOOKUP: begin
               r_raddr <= {r_blk, 3'd0};
               r_pend  <= 1'b0;
`ifdef L2R_STATS_EN
               if (w_hit) r_hit_count <= r_hit_count + 16'(r_hit_count != 16'hFFFF);
               else r_miss_count <= r_miss_count + 16'(r_miss_count != 16'hFFFF);
`endif
               if (r_we) begin
                  r_lines[w_idx] <= r_wdata;
                  r_tags[w_idx]  <= w_tag;
                  r_valid[w_idx] <= 1'b1;
                  r_wen          <= 1'b1;
                  r_ram_wdata    <= r_wdata[31:0];
                  r_state        <= WRITE;
               end else if (w_hit) begin
                  r_l2_data <= r_lines[w_idx];
                  r_done    <= 1'b1;
                  r_state   <= RESPOND;
               end else begin
                  r_ren   <= 1'b1;
                  r_state <= FILL;
               end
            end
            FILL: begin
               r_pend  <= r_ren;
               r_pbeat <= w_beat;
               r_ren   <= r_ren && w_beat != 3'd7;
               r_raddr <= r_raddr + 30'(r_ren && w_beat != 3'd7);
               if (r_pend) r_fill <= w_fill_next;
               if (r_pend && r_pbeat == 3'd7) begin
                  r_lines[w_idx] <= w_fill_next;
                  r_tags[w_idx]  <= w_tag;
                  r_valid[w_idx] <= 1'b1;
                  r_l2_data      <= w_fill_next;
                  r_done         <= 1'b1;
                  r_state        <= RESPOND;
               end
            end
            WRITE: if (w_beat == 3'd7) begin
               r_wen     <= 1'b0;
               r_l2_data <= r_wdata;
               r_done    <= 1'b1;
               r_state   <= RESPOND;
            end else begin
               r_raddr     <= r_raddr + 30'd1;
               r_ram_wdata <= r_wdata[32*(32'(w_beat)+1) +: 32];
            end
            RESPOND: begin
               r_done  <= 1'b0;
               r_state <= WAIT_DROP;
            end
            WAIT_DROP: if (!bus.l2_request) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.l2_data        = r_l2_data;
   assign bus.l2_done        = r_done;
   assign bus.ram_addr       = r_raddr;
   assign bus.ram_read_en    = r_ren;
   assign bus.ram_write_en   = r_wen;
   assign bus.ram_write_data = r_ram_wdata;
endmodule
